button_event_decoder: RTL and testbench

//  Consumes the clean level from the button debouncer and turns it into single-cycle

---
 rtl/button_event_decoder_pkg.sv | 15 +
 rtl/button_event_decoder_btn_edge_det.sv | 23 ++
 rtl/button_event_decoder.sv | 140 ++++++++++++++
 tb/tb_button_event_decoder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/button_event_decoder_pkg.sv
// Shared state encodings and 50 MHz board timing defaults
// for the button event decoder and button-driven FSMs.
package button_event_decoder_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DOWN1 = 3'd1;
    localparam logic [2:0] ST_GAP   = 3'd2;
    localparam logic [2:0] ST_DOWN2 = 3'd3;
    localparam logic [2:0] ST_LONG  = 3'd4;

    localparam int DEF_CNT_W       = 26;
    localparam int DEF_LONG_CYCLES = 50_000_000;
    localparam int DEF_GAP_CYCLES  = 12_500_000;

endpackage

// File: rtl/button_event_decoder_btn_edge_det.sv
// Edge detector for the debounced button level.
// Ports: clk, rst (sync, active high), btn_i level in,
//        rise_o / fall_o combinational edge flags.
module btn_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic rise_o,
    output logic fall_o
);

    logic btn_q;

    // Reset loads the live level so a button held through
    // reset release is not seen as a fresh press.
    always_ff @(posedge clk) begin
        btn_q <= btn_i;
    end

    assign rise_o = ~rst & btn_i & ~btn_q;
    assign fall_o = ~rst & ~btn_i & btn_q;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into 1-cycle event pulses.
// Ports: clk, rst (sync, active high), btn_level in;
//        press/release/click/double/long pulses, held level out.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LONG_CYCLES = DEF_LONG_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    logic             rise;
    logic             fall;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             click_q, click_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    logic             held_q;

    btn_edge_det u_edge (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_level),
        .rise_o (rise),
        .fall_o (fall)
    );

    // Edges take priority over timeouts in every state.
    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        double_d  = 1'b0;
        long_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    state_d = ST_DOWN1;
                end
            end
            ST_DOWN1: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = ST_GAP;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = ST_LONG;
                end
            end
            ST_GAP: begin
                if (rise) begin
                    press_d = 1'b1;
                    state_d = ST_DOWN2;
                end else if (cnt_q == GAP_LAST) begin
                    click_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DOWN2: begin
                if (fall) begin
                    release_d = 1'b1;
                    double_d  = 1'b1;
                    state_d   = ST_IDLE;
                end else if (cnt_q == LONG_LAST) begin
                    // first click is dropped once it becomes a long press
                    long_d  = 1'b1;
                    state_d = ST_LONG;
                end
            end
            ST_LONG: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counter restarts on each state change and saturates.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (&cnt_q) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            double_q  <= double_d;
            long_q    <= long_d;
            held_q    <= btn_level;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign click_pulse   = click_q;
    assign double_pulse  = double_q;
    assign long_pulse    = long_q;
    assign held          = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with short timing
// (LONG_CYCLES=20, GAP_CYCLES=8).
module tb_button_event_decoder;

    logic clk = 1'b0;
    logic rst;
    logic btn_level;
    logic press_pulse, release_pulse, click_pulse;
    logic double_pulse, long_pulse, held;

    int vectors = 0;
    int miscompares = 0;

    int cyc = 0;
    int np = 0, nr = 0, nc = 0, nd = 0, nl = 0;
    int tp = 0, tr = 0, tc = 0, td = 0, tl = 0;
    int stretch = 0;
    logic [4:0] prev_v = '0;

    int bp, br, bc, bd, bl;

    button_event_decoder #(
        .CNT_W       (6),
        .LONG_CYCLES (20),
        .GAP_CYCLES  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .click_pulse   (click_pulse),
        .double_pulse  (double_pulse),
        .long_pulse    (long_pulse),
        .held          (held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [4:0] v;
        v = {press_pulse, release_pulse, click_pulse,
             double_pulse, long_pulse};
        if (press_pulse)   begin np <= np + 1; tp <= cyc; end
        if (release_pulse) begin nr <= nr + 1; tr <= cyc; end
        if (click_pulse)   begin nc <= nc + 1; tc <= cyc; end
        if (double_pulse)  begin nd <= nd + 1; td <= cyc; end
        if (long_pulse)    begin nl <= nl + 1; tl <= cyc; end
        if ((v & prev_v) != 5'd0) stretch <= stretch + 1;
        prev_v <= v;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mark();
        bp = np; br = nr; bc = nc; bd = nd; bl = nl;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int outs();
        return int'({press_pulse, release_pulse, click_pulse,
                     double_pulse, long_pulse, held});
    endfunction

    initial begin
        rst = 1'b1;
        btn_level = 1'b0;
        tick(1);
        chk("reset_outs", outs(), 0);
        tick(2);
        rst = 1'b0;
        tick(5);

        // 1: single click
        mark();
        btn_level = 1'b1; tick(5);
        btn_level = 1'b0; tick(20);
        chk("t1_press", np - bp, 1);
        chk("t1_release", nr - br, 1);
        chk("t1_click", nc - bc, 1);
        chk("t1_double", nd - bd, 0);
        chk("t1_long", nl - bl, 0);
        chk("t1_rel_lat", tr - tp, 5);
        chk("t1_click_lat", tc - tr, 8);

        // 2: double click
        mark();
        btn_level = 1'b1; tick(5);
        btn_level = 1'b0; tick(3);
        btn_level = 1'b1; tick(5);
        btn_level = 1'b0; tick(20);
        chk("t2_press", np - bp, 2);
        chk("t2_release", nr - br, 2);
        chk("t2_double", nd - bd, 1);
        chk("t2_dbl_at_rel", td - tr, 0);
        chk("t2_click", nc - bc, 0);
        chk("t2_long", nl - bl, 0);

        // 3: long press
        mark();
        btn_level = 1'b1; tick(30);
        chk("t3_held", int'(held), 1);
        btn_level = 1'b0; tick(20);
        chk("t3_long", nl - bl, 1);
        chk("t3_long_lat", tl - tp, 20);
        chk("t3_release", nr - br, 1);
        chk("t3_rel_lat", tr - tp, 30);
        chk("t3_click", nc - bc, 0);

        // 4a: release on the long threshold cycle
        mark();
        btn_level = 1'b1; tick(20);
        btn_level = 1'b0; tick(20);
        chk("t4a_long", nl - bl, 0);
        chk("t4a_release", nr - br, 1);
        chk("t4a_rel_lat", tr - tp, 20);
        chk("t4a_click", nc - bc, 1);

        // 4b: re-press on the gap timeout cycle
        mark();
        btn_level = 1'b1; tick(5);
        btn_level = 1'b0; tick(8);
        btn_level = 1'b1; tick(3);
        btn_level = 1'b0; tick(20);
        chk("t4b_press", np - bp, 2);
        chk("t4b_click", nc - bc, 0);
        chk("t4b_double", nd - bd, 1);
        chk("t4b_release", nr - br, 2);

        // 5: held through reset
        rst = 1'b1;
        btn_level = 1'b1;
        tick(3);
        chk("t5_rst_outs", outs(), 0);
        rst = 1'b0;
        mark();
        tick(40);
        chk("t5_pulses", (np - bp) + (nr - br) + (nc - bc)
                         + (nd - bd) + (nl - bl), 0);
        chk("t5_held", int'(held), 1);
        btn_level = 1'b0; tick(3);
        mark();
        btn_level = 1'b1; tick(3);
        chk("t5_press", np - bp, 1);
        chk("t5_press_lat", tp, cyc - 2);
        btn_level = 1'b0; tick(20);

        // 6a: reset on the gap timeout cycle
        btn_level = 1'b1; tick(5);
        btn_level = 1'b0; tick(8);
        rst = 1'b1; tick(1);
        mark();
        chk("t6a_outs", outs(), 0);
        rst = 1'b0; tick(20);
        chk("t6a_click", nc - bc, 0);
        chk("t6a_any", (np - bp) + (nr - br) + (nd - bd)
                       + (nl - bl), 0);

        // 6b: reset together with the second release
        btn_level = 1'b1; tick(5);
        btn_level = 1'b0; tick(3);
        btn_level = 1'b1; tick(3);
        btn_level = 1'b0;
        rst = 1'b1; tick(1);
        mark();
        chk("t6b_outs", outs(), 0);
        rst = 1'b0; tick(20);
        chk("t6b_double", nd - bd, 0);
        chk("t6b_release", nr - br, 0);
        chk("t6b_click", nc - bc, 0);

        // 6c: one-cycle glitch
        mark();
        btn_level = 1'b1; tick(1);
        btn_level = 1'b0; tick(20);
        chk("t6c_press", np - bp, 1);
        chk("t6c_release", nr - br, 1);
        chk("t6c_rel_lat", tr - tp, 1);
        chk("t6c_click", nc - bc, 1);

        chk("no_stretch", stretch, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
